// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor: tracks the lamp phase, checks ordering
// and per-phase dwell, reports violations and counts legal cycles.
module traffic_light_monitor #(
    parameter int RED_TICS   = 350,
    parameter int GREEN_TICS = 200,
    parameter int AMBER_TICS = 30
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        red_i,
    input  logic        amber_i,
    input  logic        green_i,
    output logic [1:0]  phase_o,
    output logic        err_pulse_o,
    output logic [2:0]  err_code_o,
    output logic        err_sticky_o,
    output logic [15:0] cycle_count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RED   = 2'd1,
        S_GREEN = 2'd2,
        S_AMBER = 2'd3
    } phase_e;

    localparam logic [15:0] RED_T   = 16'(RED_TICS);
    localparam logic [15:0] GREEN_T = 16'(GREEN_TICS);
    localparam logic [15:0] AMBER_T = 16'(AMBER_TICS);

    localparam logic [2:0] E_CONFLICT = 3'd1;
    localparam logic [2:0] E_DARK     = 3'd2;
    localparam logic [2:0] E_ORDER    = 3'd3;
    localparam logic [2:0] E_DURATION = 3'd4;

    phase_e      phase_q, phase_d;
    logic [15:0] dwell_q, dwell_d;
    logic        checked_q, checked_d;
    logic        chain_q, chain_d;
    logic        pulse_q, pulse_d;
    logic [2:0]  code_q, code_d;
    logic        sticky_q, sticky_d;
    logic [15:0] count_q, count_d;

    logic [2:0]  lamps;
    logic        none, single, multi;
    phase_e      samp, succ;
    logic [15:0] exp_t;
    logic        dur_bad;
    logic        err;
    logic [2:0]  err_code;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q   <= S_IDLE;
            dwell_q   <= '0;
            checked_q <= 1'b0;
            chain_q   <= 1'b0;
            pulse_q   <= 1'b0;
            code_q    <= '0;
            sticky_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            phase_q   <= phase_d;
            dwell_q   <= dwell_d;
            checked_q <= checked_d;
            chain_q   <= chain_d;
            pulse_q   <= pulse_d;
            code_q    <= code_d;
            sticky_q  <= sticky_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        lamps  = {red_i, amber_i, green_i};
        none   = (lamps == 3'b000);
        single = $onehot(lamps);
        multi  = !none && !single;

        samp = S_AMBER;
        if (red_i)
            samp = S_RED;
        else if (green_i)
            samp = S_GREEN;

        succ  = S_IDLE;
        exp_t = '0;
        unique case (phase_q)
            S_RED:   begin succ = S_GREEN; exp_t = RED_T;   end
            S_GREEN: begin succ = S_AMBER; exp_t = GREEN_T; end
            S_AMBER: begin succ = S_RED;   exp_t = AMBER_T; end
            default: begin succ = S_IDLE;  exp_t = '0;      end
        endcase
        dur_bad = checked_q && (dwell_q != exp_t);

        phase_d   = phase_q;
        dwell_d   = dwell_q;
        checked_d = checked_q;
        chain_d   = chain_q;
        count_d   = count_q;
        err       = 1'b0;
        err_code  = '0;

        if (multi) begin
            err       = 1'b1;
            err_code  = E_CONFLICT;
            phase_d   = S_IDLE;
            dwell_d   = '0;
            checked_d = 1'b0;
            chain_d   = 1'b0;
        end else if (none) begin
            err       = (phase_q != S_IDLE);
            err_code  = E_DARK;
            phase_d   = S_IDLE;
            dwell_d   = '0;
            checked_d = 1'b0;
            chain_d   = 1'b0;
        end else if (phase_q == S_IDLE) begin
            phase_d   = samp;
            dwell_d   = 16'd1;
            checked_d = 1'b0;
            chain_d   = 1'b0;
        end else if (samp == phase_q) begin
            if (dwell_q != 16'hFFFF)
                dwell_d = dwell_q + 16'd1;
        end else if (samp == succ) begin
            err       = dur_bad;
            err_code  = E_DURATION;
            phase_d   = samp;
            dwell_d   = 16'd1;
            checked_d = 1'b1;
            // chain_q: every phase since the current RED was legal and on time
            unique case (phase_q)
                S_RED:   chain_d = !dur_bad;
                S_GREEN: chain_d = chain_q && checked_q && !dur_bad;
                default: begin
                    chain_d = 1'b0;
                    if (chain_q && checked_q && !dur_bad)
                        count_d = count_q + 16'd1;
                end
            endcase
        end else begin
            err       = 1'b1;
            err_code  = E_ORDER;
            phase_d   = samp;
            dwell_d   = 16'd1;
            checked_d = 1'b0;
            chain_d   = 1'b0;
        end

        pulse_d  = err;
        code_d   = err ? err_code : code_q;
        sticky_d = sticky_q || err;
    end

    assign phase_o       = phase_q;
    assign err_pulse_o   = pulse_q;
    assign err_code_o    = code_q;
    assign err_sticky_o  = sticky_q;
    assign cycle_count_o = count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor with short phase tics.
module tb_traffic_light_monitor;

    localparam logic [2:0] N = 3'b000;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] A = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        red = 1'b0;
    logic        amber = 1'b0;
    logic        green = 1'b0;
    logic [1:0]  phase;
    logic        err_pulse;
    logic [2:0]  err_code;
    logic        err_sticky;
    logic [15:0] cycle_count;

    typedef struct {
        logic [1:0]  ph;
        logic        pl;
        logic [2:0]  cd;
        logic        st;
        logic [15:0] cc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [2:0]  e_code = '0;
    logic        e_st   = 1'b0;
    logic [15:0] e_cc   = '0;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .RED_TICS  (5),
        .GREEN_TICS(3),
        .AMBER_TICS(2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .red_i        (red),
        .amber_i      (amber),
        .green_i      (green),
        .phase_o      (phase),
        .err_pulse_o  (err_pulse),
        .err_code_o   (err_code),
        .err_sticky_o (err_sticky),
        .cycle_count_o(cycle_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".phase"}, 16'(phase), 16'd0);
        chk({tag, ".pulse"}, 16'(err_pulse), 16'd0);
        chk({tag, ".code"}, 16'(err_code), 16'd0);
        chk({tag, ".sticky"}, 16'(err_sticky), 16'd0);
        chk({tag, ".count"}, cycle_count, 16'd0);
    endtask

    task automatic stp(input string tag, input logic [2:0] l,
                       input logic [1:0] ph, input logic [2:0] err);
        exp_t e;
        if (err != 3'd0) begin
            e_code = err;
            e_st   = 1'b1;
        end
        e = '{ph, (err != 3'd0), e_code, e_st, e_cc};
        @(negedge clk);
        {red, amber, green} = l;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".phase"}, 16'(phase), 16'(e.ph));
        chk({tag, ".pulse"}, 16'(err_pulse), 16'(e.pl));
        chk({tag, ".code"}, 16'(err_code), 16'(e.cd));
        chk({tag, ".sticky"}, 16'(err_sticky), 16'(e.st));
        chk({tag, ".count"}, cycle_count, e.cc);
    endtask

    task automatic rep(input string tag, input logic [2:0] l,
                       input int n, input logic [1:0] ph);
        for (int i = 0; i < n; i++)
            stp(tag, l, ph, 3'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // legal cycle; RED entered from IDLE
        rep("s1.r", R, 5, 2'd1);
        rep("s1.g", G, 3, 2'd2);
        rep("s1.a", A, 2, 2'd3);
        e_cc = 16'd1;
        stp("s1.r2", R, 2'd1, 3'd0);
        rep("s1.r3", R, 4, 2'd1);

        // long green
        rep("s2.g", G, 4, 2'd2);
        stp("s2.a", A, 2'd3, 3'd4);
        stp("s2.a2", A, 2'd3, 3'd0);
        stp("s2.r", R, 2'd1, 3'd0);
        rep("s2.r2", R, 4, 2'd1);

        // second legal cycle from a checked RED
        rep("s2b.g", G, 3, 2'd2);
        rep("s2b.a", A, 2, 2'd3);
        e_cc = 16'd2;
        stp("s2b.r", R, 2'd1, 3'd0);

        // conflict in GREEN, then AMBER from IDLE
        rep("s3.r", R, 4, 2'd1);
        stp("s3.g", G, 2'd2, 3'd0);
        stp("s3.ga", 3'b011, 2'd0, 3'd1);
        stp("s3.a", A, 2'd3, 3'd0);
        stp("s3.a2", A, 2'd3, 3'd0);
        stp("s3.r", R, 2'd1, 3'd0);

        // order error in RED, unchecked AMBER
        stp("s4.ra", A, 2'd3, 3'd3);
        stp("s4.a", A, 2'd3, 3'd0);
        stp("s4.r", R, 2'd1, 3'd0);

        // short checked RED and GREEN, then dark
        stp("s5.g", G, 2'd2, 3'd4);
        stp("s5.a", A, 2'd3, 3'd4);
        stp("s5.n", N, 2'd0, 3'd2);
        rep("s5.nn", N, 10, 2'd0);
        stp("s5.rg", 3'b101, 2'd0, 3'd1);
        stp("s5.all", 3'b111, 2'd0, 3'd1);

        // async reset mid-GREEN
        stp("s6.g", G, 2'd2, 3'd0);
        stp("s6.g2", G, 2'd2, 3'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("s6.rst");
        #1;
        rst = 1'b0;
        e_code = '0;
        e_st   = 1'b0;
        e_cc   = '0;
        rep("s6.g3", G, 2, 2'd2);
        stp("s6.a", A, 2'd3, 3'd0);

        chk("sb.empty", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
